// File: rtl/priority_arbiter_4.sv
// priority_arbiter_4
// Four-way request arbiter with a registered one-hot grant. Arbitration
// happens only while idle; once a requester is granted it keeps the grant
// until it drops its request or until it has held the grant for MAX_HOLD
// cycles. After every release there is at least one idle cycle before the
// next grant.
//
// Parameters
//   MAX_HOLD     : maximum consecutive grant cycles before forced release
//                  (0 = unlimited)
// Ports
//   clk          : single clock, all state changes on its rising edge
//   rst_n        : synchronous active-low reset
//   req[3:0]     : request lines, one per requester
//   rr_mode      : 0 = fixed priority (3 highest), 1 = round-robin
//   gnt[3:0]     : registered one-hot grant
//   gnt_id[1:0]  : registered index of the granted requester (0 while idle)
//   gnt_valid    : high while a grant is active (|gnt)
//   hold_expired : one-cycle pulse in the idle cycle after a forced release

module priority_arbiter_4 #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       rr_mode,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic       hold_expired
);

  localparam int CW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  // Counter value seen during the last permitted grant cycle: the counter
  // is zero in the first grant cycle.
  localparam logic [CW-1:0] HOLD_LAST    = (MAX_HOLD < 1) ? '0 : CW'(MAX_HOLD - 1);
  localparam logic [CW-1:0] CNT_MAX      = '1;
  localparam bit            HOLD_LIMITED = (MAX_HOLD != 0);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      gnt_q, gnt_d;
  logic [1:0]      gnt_id_q, gnt_id_d;
  logic [1:0]      last_id_q, last_id_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            hold_exp_q, hold_exp_d;

  logic [1:0]      winner;
  logic [1:0]      cand;
  logic            found;
  logic            owner_req;

  assign owner_req = req[gnt_id_q];

  // Winner selection. Round-robin searches last_id-1, -2, -3 and finally
  // last_id itself (2-bit subtraction wraps naturally); fixed priority lets
  // the highest asserted index overwrite lower ones.
  always_comb begin
    winner = 2'd0;
    cand   = 2'd0;
    found  = 1'b0;
    if (rr_mode) begin
      for (int k = 1; k <= 4; k++) begin
        cand = last_id_q - 2'(k);
        if (!found && req[cand]) begin
          winner = cand;
          found  = 1'b1;
        end
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (req[k]) winner = 2'(k);
      end
    end
  end

  // Next-state logic. While granting, only the owner's request line matters.
  // A release caused by the owner dropping its request is voluntary even if
  // the hold limit is reached on the same edge, so no pulse in that case.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gnt_id_d   = gnt_id_q;
    last_id_d  = last_id_q;
    cnt_d      = cnt_q;
    hold_exp_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req != 4'b0000) begin
          state_d  = GRANT;
          gnt_d    = 4'b0001 << winner;
          gnt_id_d = winner;
          cnt_d    = '0;
        end
      end
      GRANT: begin
        if (!owner_req || (HOLD_LIMITED && cnt_q == HOLD_LAST)) begin
          state_d    = IDLE;
          gnt_d      = 4'b0000;
          gnt_id_d   = 2'd0;
          last_id_d  = gnt_id_q;
          hold_exp_d = owner_req;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  // State register with synchronous active-low reset taking priority over
  // everything, including an active grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= 4'b0000;
      gnt_id_q   <= 2'd0;
      last_id_q  <= 2'd0;
      cnt_q      <= '0;
      hold_exp_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_id_q   <= gnt_id_d;
      last_id_q  <= last_id_d;
      cnt_q      <= cnt_d;
      hold_exp_q <= hold_exp_d;
    end
  end

  assign gnt          = gnt_q;
  assign gnt_id       = gnt_id_q;
  assign gnt_valid    = |gnt_q;
  assign hold_expired = hold_exp_q;

endmodule
